mul_result_select: RTL and testbench

MUL_RESULT_SELECT -- requirements
Module: mul_result_select

---
 rtl/mul_result_select.sv | 119 +++++++++++
 tb/tb_mul_result_select.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_result_select.sv
// Result select stage for the vedic multiplier: per-lane sign correction,
// low/high half selection, and a one-entry skid buffer on the output.

// One lane: optionally two's-complement the 2*SEW magnitude, then pick a half.
module mul_result_lane #(
  parameter int SEW = 8
) (
  input  logic [2*SEW-1:0] mag,
  input  logic             negate,
  input  logic             high,
  output logic [SEW-1:0]   res
);
  logic [2*SEW-1:0] fixed;

  // Negation is done at full lane width, so -0 stays 0 and no carry can
  // leave the lane.
  assign fixed = negate ? ({(2*SEW){1'b0}} - mag) : mag;
  assign res   = high ? fixed[2*SEW-1:SEW] : fixed[SEW-1:0];
endmodule

module mul_result_select #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_product,
  input  logic [3:0]       in_negate,
  input  logic [1:0]       in_precision,
  input  logic [1:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);
  logic             high;
  logic [3:0][7:0]  res8;
  logic [1:0][15:0] res16;
  logic [31:0]      res32;
  logic [31:0]      beat_result;

  logic             skid_valid;
  logic [31:0]      skid_result;
  logic [TAG_W-1:0] skid_tag;

  // Any opcode other than MUL returns the high half.
  assign high = |in_opcode;

  // All three lane layouts are computed in parallel; precision picks one.
  for (genvar i = 0; i < 4; i++) begin : g_l8
    mul_result_lane #(.SEW(8)) u_lane (
      .mag    (in_product[16*i +: 16]),
      .negate (in_negate[i]),
      .high   (high),
      .res    (res8[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_l16
    mul_result_lane #(.SEW(16)) u_lane (
      .mag    (in_product[32*i +: 32]),
      .negate (in_negate[i]),
      .high   (high),
      .res    (res16[i])
    );
  end

  mul_result_lane #(.SEW(32)) u_l32 (
    .mag    (in_product),
    .negate (in_negate[0]),
    .high   (high),
    .res    (res32)
  );

  // Precision mux; the reserved encoding 11 behaves as 32-bit.
  always_comb begin
    beat_result = res32;
    case (in_precision)
      2'b00:   beat_result = res8;
      2'b01:   beat_result = res16;
      default: beat_result = res32;
    endcase
  end

  // in_ready comes straight from the skid flop, no path from out_ready.
  assign in_ready = !skid_valid;

  // Output register plus skid: refill from skid first, otherwise take the
  // new beat; a beat arriving while the output is stalled parks in skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_tag    <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_result <= skid_result;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        out_valid  <= 1'b1;
        out_result <= beat_result;
        out_tag    <= in_tag;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid  <= 1'b1;
      skid_result <= beat_result;
      skid_tag    <= in_tag;
    end
  end
endmodule

// File: tb/tb_mul_result_select.sv
// Bench for mul_result_select: directed corner vectors, back-pressure,
// reset mid-flight, then random traffic against an in-order reference queue.
module tb_mul_result_select;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_product = '0;
  logic [3:0]       in_negate = '0;
  logic [1:0]       in_precision = '0;
  logic [1:0]       in_opcode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0]      r;
    logic [TAG_W-1:0] t;
  } item_t;

  item_t q[$];
  int tests = 0;
  int failed = 0;

  mul_result_select #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_negate    (in_negate),
    .in_precision (in_precision),
    .in_opcode    (in_opcode),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: signed value of each lane as arithmetic mod 2^(2*SEW), then
  // take the requested SEW-bit half.
  function automatic logic [31:0] ref_result(logic [63:0] p, logic [3:0] ng,
                                             logic [1:0] pr, logic [1:0] op);
    int sew;
    int lanes;
    logic [63:0] mask;
    logic [63:0] smask;
    logic [63:0] m;
    logic [31:0] r;
    sew   = (pr == 2'b00) ? 8 : (pr == 2'b01) ? 16 : 32;
    lanes = 32 / sew;
    mask  = (sew == 32) ? {64{1'b1}} : ((64'd1 << (2 * sew)) - 64'd1);
    smask = (64'd1 << sew) - 64'd1;
    r     = '0;
    for (int i = 0; i < lanes; i++) begin
      m = (p >> (2 * sew * i)) & mask;
      if (ng[i]) m = (64'd0 - m) & mask;
      m = (op == 2'b00) ? (m & smask) : ((m >> sew) & smask);
      r = r | 32'(m << (sew * i));
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, note which transfers happen at the edge,
  // advance the reference queue, then compare outputs after the edge.
  task automatic step(bit iv, logic [63:0] p, logic [3:0] ng, logic [1:0] pr,
                      logic [1:0] op, logic [TAG_W-1:0] tg, bit ordy);
    bit pre_in;
    bit pre_out;
    item_t e;
    in_valid = iv; in_product = p; in_negate = ng;
    in_precision = pr; in_opcode = op; in_tag = tg; out_ready = ordy;
    pre_in  = iv && in_ready;
    pre_out = out_valid && ordy;
    e.r = ref_result(p, ng, pr, op);
    e.t = tg;
    @(posedge clk);
    #1;
    if (pre_out && q.size() > 0) void'(q.pop_front());
    if (pre_in) q.push_back(e);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_result", 64'(out_result), 64'(q[0].r));
      chk("out_tag", 64'(out_tag), 64'(q[0].t));
    end
  endtask

  task automatic idle(bit ordy);
    step(1'b0, '0, '0, '0, '0, '0, ordy);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 32-bit negate, high then low half
    step(1'b1, 64'h6, 4'b0001, 2'b10, 2'b01, 4'd1, 1'b1);
    chk("mulh32_neg", 64'(out_result), 64'hFFFF_FFFF);
    step(1'b1, 64'h6, 4'b0001, 2'b10, 2'b00, 4'd2, 1'b1);
    chk("mul32_neg", 64'(out_result), 64'hFFFF_FFFA);
    // 8-bit lanes, alternate negation, no cross-lane carry
    step(1'b1, 64'h0006_0006_0006_0006, 4'b0101, 2'b00, 2'b00, 4'd3, 1'b1);
    chk("mul8_mix", 64'(out_result), 64'h06FA_06FA);
    // Negated zero at 16-bit stays zero
    step(1'b1, 64'h0, 4'b0011, 2'b01, 2'b10, 4'd4, 1'b1);
    chk("neg_zero16", 64'(out_result), 64'h0);
    // Unused negate bits ignored at 32-bit; precision 11 acts as 32-bit
    step(1'b1, 64'h0000_0001_0000_0002, 4'b1110, 2'b11, 2'b11, 4'd5, 1'b1);
    chk("prec11_ign", 64'(out_result), 64'h1);
    idle(1'b1);

    // Back-pressure: three beats offered, two accepted, then drain
    step(1'b1, 64'h11, 4'b0, 2'b10, 2'b00, 4'hA, 1'b0);
    step(1'b1, 64'h22, 4'b0, 2'b10, 2'b00, 4'hB, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 64'h33, 4'b0, 2'b10, 2'b00, 4'hC, 1'b0);
    chk("bp_third_held", 64'(out_tag), 64'hA);
    idle(1'b1);
    chk("bp_drain_tag_b", 64'(out_tag), 64'hB);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Streaming: one result per cycle, tags 0..15
    for (int i = 0; i < 16; i++) begin
      step(1'b1, {$urandom, $urandom}, 4'($urandom), 2'($urandom), 2'($urandom),
           TAG_W'(i), 1'b1);
      chk("stream_tag", 64'(out_tag), 64'(i));
    end
    idle(1'b1);

    // Reset with output and skid both full
    step(1'b1, 64'h44, 4'b0, 2'b10, 2'b00, 4'd6, 1'b0);
    step(1'b1, 64'h55, 4'b0, 2'b10, 2'b00, 4'd7, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rr_out_valid", 64'(out_valid), 64'd0);
    chk("rr_in_ready", 64'(in_ready), 64'd1);
    chk("rr_out_result", 64'(out_result), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 64'h77, 4'b0, 2'b10, 2'b00, 4'd9, 1'b1);
    chk("rr_first_beat", 64'(out_tag), 64'd9);
    idle(1'b1);
    chk("rr_no_stale", 64'(out_valid), 64'd0);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), {$urandom, $urandom}, 4'($urandom), 2'($urandom),
           2'($urandom), TAG_W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
